// File: rtl/store_pkg.sv
// Shared encodings for the store read-modify-write unit: access sizes,
// FSM states and the alignment rule used to reject illegal stores.
package store_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Bytes are always aligned; halves need an even offset, words offset 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size_e'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces one big-endian byte or halfword lane of a memory word with new
// store data; word stores pass the new data through unchanged.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [WORD_W-1:0] old_word_i,
    input  logic [WORD_W-1:0] new_data_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        offset_i,
    output logic [WORD_W-1:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        case (size_e'(size_i))
            SZ_BYTE: begin
                // Offset 0 is the most significant byte.
                case (offset_i)
                    2'd0:    merged_o[31:24] = new_data_i[7:0];
                    2'd1:    merged_o[23:16] = new_data_i[7:0];
                    2'd2:    merged_o[15:8]  = new_data_i[7:0];
                    default: merged_o[7:0]   = new_data_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1] == 1'b0) begin
                    merged_o[31:16] = new_data_i[15:0];
                end else begin
                    merged_o[15:0] = new_data_i[15:0];
                end
            end
            SZ_WORD: merged_o = new_data_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Narrows sb/sh/sw stores onto a word-only data memory. Word stores write
// directly; byte and half stores read the word, merge the lane, write back.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    output logic                  done,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    // Handshake: a request transfers on any rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE, and the
    // requester holds its request stable until that transfer occurs.

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] merged;
    logic                  accept;

    assign accept = req_valid && req_ready;

    store_lane_merge u_merge (
        .old_word_i (mem_rdata),
        .new_data_i (wdata_q),
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .merged_o   (merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
        end
    end

    // wdata_q holds the raw store data until the read returns, then the
    // merged word, so the write stage always drives wdata_q.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        if (accept) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            size_d  = req_size;
        end else if (state_q == WAIT && mem_rvalid) begin
            wdata_d = merged;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ERR;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = WAIT;
            WAIT:    if (mem_rvalid) state_d = WRITE;
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_re     = (state_q == READ);
        mem_we     = (state_q == WRITE);
        done       = (state_q == WRITE) || (state_q == ERR);
        misaligned = (state_q == ERR);
        mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata  = wdata_q;
    end

endmodule
